// File: rtl/seq_arb_pkg.sv
// Shared constants and helpers for the 4-input grant-hold arbiter front-end.
package seq_arb_pkg;

  localparam int NPORTS    = 4;
  localparam int SRC_NBITS = 2;

  // True when more than one bit of a port vector is set.
  function automatic logic multi_hot(input logic [NPORTS-1:0] v);
    return (v & (v - {{(NPORTS-1){1'b0}}, 1'b1})) != '0;
  endfunction

endpackage

// File: rtl/seq_arb_pkt_fifo.sv
// Per-port beat FIFO; push_rdy depends only on the registered count.
module seq_arb_pkt_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_val,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_en,
  output logic             pop_val,
  output logic [WIDTH-1:0] pop_data
);

  localparam int PTR_NBITS = $clog2(DEPTH);
  localparam int CNT_NBITS = PTR_NBITS + 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_NBITS-1:0] wr_ptr;
  logic [PTR_NBITS-1:0] rd_ptr;
  logic [CNT_NBITS-1:0] count;
  logic                 do_push;
  logic                 do_pop;

  assign push_rdy = count != CNT_NBITS'(DEPTH);
  assign pop_val  = count != '0;
  assign do_push  = push_val && push_rdy;
  assign do_pop   = pop_en && pop_val;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_NBITS'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_NBITS'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_NBITS'(1);
        2'b01:   count <= count - CNT_NBITS'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/seq_arb_pkt_frontend_4in.sv
// Front-end for the 4-input grant-hold arbiter: buffers packets per port,
// drives reqs/holds, pops the granted beat and forwards it registered.
module seq_arb_pkt_frontend_4in
  import seq_arb_pkg::*;
#(
  parameter int MSG_NBITS = 8,
  parameter int DEPTH     = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NPORTS-1:0]             in_val,
  output logic [NPORTS-1:0]             in_rdy,
  input  logic [NPORTS*MSG_NBITS-1:0]   in_msg,
  input  logic [NPORTS-1:0]             in_last,
  output logic [NPORTS-1:0]             reqs,
  output logic [NPORTS-1:0]             holds,
  input  logic [NPORTS-1:0]             grants,
  output logic                          out_val,
  output logic [MSG_NBITS-1:0]          out_msg,
  output logic                          out_last,
  output logic [SRC_NBITS-1:0]          out_src,
  output logic                          err
);

  typedef struct packed {
    logic                 last;
    logic [MSG_NBITS-1:0] msg;
  } beat_t;

  beat_t                 push_beat [NPORTS];
  beat_t                 head      [NPORTS];
  beat_t                 popped;
  logic [NPORTS-1:0]     not_empty;
  logic [NPORTS-1:0]     pop_en;
  logic [NPORTS-1:0]     pkt_active;
  logic                  pop_any;
  logic [SRC_NBITS-1:0]  pop_idx;
  logic                  lock_conflict;
  logic                  err_now;

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    assign push_beat[i] = {in_last[i], in_msg[i*MSG_NBITS +: MSG_NBITS]};

    seq_arb_pkt_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(beat_t))
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_val  (in_val[i]),
      .push_rdy  (in_rdy[i]),
      .push_data (push_beat[i]),
      .pop_en    (pop_en[i]),
      .pop_val   (not_empty[i]),
      .pop_data  (head[i])
    );
  end

  assign reqs  = not_empty;
  assign holds = pkt_active;

  // Only the lowest granted non-empty port pops, even under an illegal grant.
  always_comb begin
    pop_any = 1'b0;
    pop_idx = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (grants[i] && not_empty[i]) begin
        pop_any = 1'b1;
        pop_idx = SRC_NBITS'(i);
      end
    end
  end

  assign pop_en = pop_any ? (NPORTS'(1) << pop_idx) : '0;
  assign popped = head[pop_idx];

  always_comb begin
    lock_conflict = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      for (int j = 0; j < NPORTS; j++) begin
        if (i != j && pkt_active[i] && grants[j]) lock_conflict = 1'b1;
      end
    end
  end

  assign err_now = multi_hot(grants) ||
                   ((grants & ~not_empty & ~pkt_active) != '0) ||
                   lock_conflict;

  // A bubble grant (held port, empty FIFO) leaves the lock and payload untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_active <= '0;
      out_val    <= 1'b0;
      out_msg    <= '0;
      out_last   <= 1'b0;
      out_src    <= '0;
      err        <= 1'b0;
    end else begin
      out_val <= pop_any;
      if (pop_any) begin
        out_msg             <= popped.msg;
        out_last            <= popped.last;
        out_src             <= pop_idx;
        pkt_active[pop_idx] <= !popped.last;
      end
      if (err_now) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_arb_pkt_frontend_4in.sv
// Directed bench: table of per-cycle vectors plus hand sequences for
// packet locking, illegal grants and mid-packet reset.
module tb_seq_arb_pkt_frontend_4in;

  logic        clk;
  logic        reset;
  logic [3:0]  in_val;
  logic [3:0]  in_rdy;
  logic [31:0] in_msg;
  logic [3:0]  in_last;
  logic [3:0]  reqs;
  logic [3:0]  holds;
  logic [3:0]  grants;
  logic        out_val;
  logic [7:0]  out_msg;
  logic        out_last;
  logic [1:0]  out_src;
  logic        err;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [3:0]  val;
    logic [31:0] msg;
    logic [3:0]  last;
    logic [3:0]  gnt;
    logic [24:0] exp;
  } vec_t;

  vec_t vecs[$];

  seq_arb_pkt_frontend_4in #(.MSG_NBITS(8), .DEPTH(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_msg   (in_msg),
    .in_last  (in_last),
    .reqs     (reqs),
    .holds    (holds),
    .grants   (grants),
    .out_val  (out_val),
    .out_msg  (out_msg),
    .out_last (out_last),
    .out_src  (out_src),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] mk(input logic [3:0] rdy, input logic [3:0] rq,
                                     input logic [3:0] hd, input logic ov,
                                     input logic [7:0] om, input logic ol,
                                     input logic [1:0] os, input logic er);
    return {rdy, rq, hd, ov, om, ol, os, er};
  endfunction

  task automatic addVec(input logic [3:0] val, input logic [31:0] msg,
                        input logic [3:0] last, input logic [3:0] gnt,
                        input logic [24:0] exp);
    vec_t v;
    v.val = val; v.msg = msg; v.last = last; v.gnt = gnt; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic [3:0] val, input logic [31:0] msg,
                               input logic [3:0] last, input logic [3:0] gnt);
    in_val  = val;
    in_msg  = msg;
    in_last = last;
    grants  = gnt;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(4'b0, 32'h0, 4'b0, 4'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_in_rdy", 32'(in_rdy), 32'hF);
    checkOutput("rst_err", 32'(err), 32'h0);
    reset = 1'b0;
    cycle();

    // rows: inputs this cycle | outputs visible before the consuming posedge
    addVec(4'h0, 32'h0,        4'h0, 4'h0, mk(4'hF, 4'h0, 4'h0, 0, 8'h00, 0, 2'd0, 0));
    addVec(4'h4, 32'h00A10000, 4'h4, 4'h0, mk(4'hF, 4'h0, 4'h0, 0, 8'h00, 0, 2'd0, 0));
    addVec(4'h0, 32'h0,        4'h0, 4'h4, mk(4'hF, 4'h4, 4'h0, 0, 8'h00, 0, 2'd0, 0));
    addVec(4'h0, 32'h0,        4'h0, 4'h0, mk(4'hF, 4'h0, 4'h0, 1, 8'hA1, 1, 2'd2, 0));
    addVec(4'h0, 32'h0,        4'h0, 4'h0, mk(4'hF, 4'h0, 4'h0, 0, 8'hA1, 1, 2'd2, 0));
    addVec(4'h8, 32'hB0000000, 4'h8, 4'h0, mk(4'hF, 4'h0, 4'h0, 0, 8'hA1, 1, 2'd2, 0));
    addVec(4'h8, 32'hB1000000, 4'h8, 4'h0, mk(4'hF, 4'h8, 4'h0, 0, 8'hA1, 1, 2'd2, 0));
    addVec(4'h8, 32'hB2000000, 4'h8, 4'h0, mk(4'h7, 4'h8, 4'h0, 0, 8'hA1, 1, 2'd2, 0));
    addVec(4'h0, 32'h0,        4'h0, 4'h8, mk(4'h7, 4'h8, 4'h0, 0, 8'hA1, 1, 2'd2, 0));
    addVec(4'h0, 32'h0,        4'h0, 4'h0, mk(4'hF, 4'h8, 4'h0, 1, 8'hB0, 1, 2'd3, 0));
    addVec(4'h0, 32'h0,        4'h0, 4'h8, mk(4'hF, 4'h8, 4'h0, 0, 8'hB0, 1, 2'd3, 0));
    addVec(4'h0, 32'h0,        4'h0, 4'h0, mk(4'hF, 4'h0, 4'h0, 1, 8'hB1, 1, 2'd3, 0));
    addVec(4'h0, 32'h0,        4'h0, 4'h0, mk(4'hF, 4'h0, 4'h0, 0, 8'hB1, 1, 2'd3, 0));
    addVec(4'h2, 32'h00003000, 4'h2, 4'h0, mk(4'hF, 4'h0, 4'h0, 0, 8'hB1, 1, 2'd3, 0));
    addVec(4'h2, 32'h00003100, 4'h2, 4'h2, mk(4'hF, 4'h2, 4'h0, 0, 8'hB1, 1, 2'd3, 0));
    addVec(4'h0, 32'h0,        4'h0, 4'h0, mk(4'hF, 4'h2, 4'h0, 1, 8'h30, 1, 2'd1, 0));
    addVec(4'h0, 32'h0,        4'h0, 4'h2, mk(4'hF, 4'h2, 4'h0, 0, 8'h30, 1, 2'd1, 0));
    addVec(4'h0, 32'h0,        4'h0, 4'h0, mk(4'hF, 4'h0, 4'h0, 1, 8'h31, 1, 2'd1, 0));
    addVec(4'h0, 32'h0,        4'h0, 4'h0, mk(4'hF, 4'h0, 4'h0, 0, 8'h31, 1, 2'd1, 0));
    addVec(4'h8, 32'hC0000000, 4'h8, 4'h0, mk(4'hF, 4'h0, 4'h0, 0, 8'h31, 1, 2'd1, 0));
    addVec(4'h8, 32'hC1000000, 4'h8, 4'h0, mk(4'hF, 4'h8, 4'h0, 0, 8'h31, 1, 2'd1, 0));
    addVec(4'h8, 32'hC2000000, 4'h8, 4'h8, mk(4'h7, 4'h8, 4'h0, 0, 8'h31, 1, 2'd1, 0));
    addVec(4'h0, 32'h0,        4'h0, 4'h8, mk(4'hF, 4'h8, 4'h0, 1, 8'hC0, 1, 2'd3, 0));
    addVec(4'h0, 32'h0,        4'h0, 4'h0, mk(4'hF, 4'h0, 4'h0, 1, 8'hC1, 1, 2'd3, 0));
    addVec(4'h0, 32'h0,        4'h0, 4'h0, mk(4'hF, 4'h0, 4'h0, 0, 8'hC1, 1, 2'd3, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].val, vecs[i].msg, vecs[i].last, vecs[i].gnt);
      #1;
      checkOutput($sformatf("vec%0d", i),
                  32'({in_rdy, reqs, holds, out_val, out_msg, out_last, out_src, err}),
                  32'(vecs[i].exp));
      cycle();
    end

    // Three-beat packet on port 0 trickling in, port 1 waiting behind the lock.
    applyStimulus(4'b0011, 32'h00002010, 4'b0010, 4'b0000); cycle();
    applyStimulus(4'b0000, 32'h0, 4'b0000, 4'b0001); #1;
    checkOutput("pk_reqs_c1", 32'(reqs), 32'h3); cycle();
    applyStimulus(4'b0000, 32'h0, 4'b0000, 4'b0001); #1;
    checkOutput("pk_holds_c2", 32'(holds), 32'h1);
    checkOutput("pk_out_c2", 32'({out_val, out_src, out_msg}), 32'({1'b1, 2'd0, 8'h10}));
    cycle();
    applyStimulus(4'b0001, 32'h00000011, 4'b0000, 4'b0001); #1;
    checkOutput("pk_bubble_c3", 32'({out_val, holds}), 32'({1'b0, 4'h1})); cycle();
    applyStimulus(4'b0000, 32'h0, 4'b0000, 4'b0001); #1;
    checkOutput("pk_c4", 32'({out_val, reqs}), 32'({1'b0, 4'h3})); cycle();
    applyStimulus(4'b0000, 32'h0, 4'b0000, 4'b0001); #1;
    checkOutput("pk_out_c5", 32'({out_val, out_msg, holds}), 32'({1'b1, 8'h11, 4'h1})); cycle();
    applyStimulus(4'b0001, 32'h00000012, 4'b0001, 4'b0001); #1;
    checkOutput("pk_bubble_c6", 32'({out_val, holds}), 32'({1'b0, 4'h1})); cycle();
    applyStimulus(4'b0000, 32'h0, 4'b0000, 4'b0001); #1;
    checkOutput("pk_c7", 32'({reqs, holds}), 32'({4'h3, 4'h1})); cycle();
    applyStimulus(4'b0000, 32'h0, 4'b0000, 4'b0010); #1;
    checkOutput("pk_out_c8", 32'({out_val, out_last, out_src, out_msg}), 32'({1'b1, 1'b1, 2'd0, 8'h12}));
    checkOutput("pk_unlock_c8", 32'({holds, reqs}), 32'({4'h0, 4'h2}));
    cycle();
    applyStimulus(4'b0000, 32'h0, 4'b0000, 4'b0000); #1;
    checkOutput("pk_out_c9", 32'({out_val, out_src, out_msg}), 32'({1'b1, 2'd1, 8'h20}));
    checkOutput("pk_err_c9", 32'({reqs, err}), 32'h0);
    cycle();

    // Grant to an empty, unlocked port is a protocol error.
    applyStimulus(4'b0000, 32'h0, 4'b0000, 4'b0100); cycle();
    applyStimulus(4'b0000, 32'h0, 4'b0000, 4'b0000); #1;
    checkOutput("empty_grant_err", 32'({out_val, err}), 32'({1'b0, 1'b1}));
    reset = 1'b1; cycle(); reset = 1'b0; cycle();
    #1 checkOutput("err_cleared", 32'(err), 32'h0);

    // Multi-hot grant, then reset while port 0 is locked with a beat buffered.
    applyStimulus(4'b0011, 32'h0000D1D0, 4'b0010, 4'b0000); cycle();
    applyStimulus(4'b0000, 32'h0, 4'b0000, 4'b0011); cycle();
    applyStimulus(4'b0001, 32'h000000D2, 4'b0000, 4'b0000); #1;
    checkOutput("mh_err", 32'(err), 32'h1);
    checkOutput("mh_pop_low", 32'({out_val, out_src, out_msg}), 32'({1'b1, 2'd0, 8'hD0}));
    checkOutput("mh_state", 32'({holds, reqs}), 32'({4'h1, 4'h2}));
    cycle();
    applyStimulus(4'b0000, 32'h0, 4'b0000, 4'b0000); #1;
    checkOutput("mh_err_sticky", 32'({err, reqs}), 32'({1'b1, 4'h3}));
    #1 reset = 1'b1;
    #1 checkOutput("rst_mid_pkt", 32'({in_rdy, reqs, holds, err, out_val, out_msg}),
                   32'({4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00}));
    cycle(); reset = 1'b0; cycle();
    #1 checkOutput("post_rst_idle", 32'({reqs, holds, err}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_arb_pkt_frontend_4in.md
Name: seq_arb_pkt_frontend_4in

Overview:
- Upstream front-end for the 4-input round-robin grant-hold arbiter.
- Buffers multi-beat packets from four sources in per-port FIFOs and drives the arbiter's reqs/holds. It consumes the arbiter's one-hot grants, pops the granted beat and forwards it on a registered output channel.
- Holds lock a port for the length of a packet, so packets are never interleaved.

Parameters:
- MSG_NBITS, 8, width of one beat payload
- DEPTH, 2, entries per input FIFO (power of two, >=2)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_val  input  4  per-port beat valid
- in_rdy  output  4  per-port not-full
- in_msg  input  4*MSG_NBITS  per-port payload; port i occupies bits [i*MSG_NBITS +: MSG_NBITS]
- in_last  input  4  per-port last-beat-of-packet flag
- reqs  output  4  to arbiter; reqs[i] = FIFO i non-empty
- holds  output  4  to arbiter; holds[i] = pkt_active[i]
- grants  input  4  from arbiter; one-hot or zero
- out_val  output  1  forwarded beat valid (registered)
- out_msg  output  MSG_NBITS  forwarded payload
- out_last  output  1  forwarded last flag
- out_src  output  2  source port of forwarded beat
- err  output  1  sticky protocol-error flag

Behaviour:
- Reset: one clock domain. reset (async, active-high) clears all FIFOs to empty, pkt_active=0000, out_val=0, out_msg=0, out_last=0, out_src=0, err=0.
- Resulting output values in reset: in_rdy=1111, reqs=0000, holds=0000.
- Reset asserted mid-packet discards all buffered beats and clears every lock.
- Push: in_val[i] && in_rdy[i] at posedge enqueues {in_last[i], in_msg[i]} into FIFO i.
  - in_rdy[i] depends on the registered count only, not on same-cycle pop.
  - A full FIFO therefore refuses a push even when it is being popped that cycle.
- Pop: grants[i] && FIFO i non-empty pops the head in the same cycle.
  - Next posedge: out_val=1, out_msg=head msg, out_last=head last, out_src=i. Latency from grant to out_val is 1 cycle.
- No grant, or grant to an empty FIFO (hold bubble): next cycle out_val=0. out_msg/out_last/out_src keep their previous values.
- pkt_active[i]:
  - set at the posedge that pops a beat of port i with last=0;
  - cleared at the posedge that pops a beat with last=1;
  - single-beat packets never set it.
- The arbiter re-grants the held port while holds[i]=1, even if its FIFO is empty. Such a cycle is a bubble: no pop, pkt_active unchanged, the lock persists until the next beat arrives.
- Push and pop on the same FIFO in the same cycle: count unchanged, both take effect.
- FIFO pointers wrap modulo DEPTH. Count is clog2(DEPTH)+1 bits. Full is count==DEPTH.
- err sets, and stays set until reset, when:
  - grants has more than one bit set;
  - a nonzero grant targets a port i with FIFO i empty and pkt_active[i]=0;
  - a grant to port j arrives while pkt_active[i]=1 for some i!=j.
- On error the pop still occurs only for the lowest granted non-empty port. The other state rules are unchanged.
- No combinational path from grants to in_rdy, reqs or holds. A grants->pop->FIFO path is permitted.

Decomposition:
- Shared package seq_arb_pkg: NPORTS=4, SRC_NBITS=2, and a beat struct {last, msg} parameterised by MSG_NBITS via a typedef in the top.
- One sub-module: seq_arb_pkt_fifo.
  - Parameterised DEPTH/width, async-reset FIFO.
  - Ports: push_val, push_rdy, push_data, pop_en, pop_val, pop_data.
  - Instantiated 4x.
- Top holds pkt_active, the output register, the error logic and the one-hot-to-index encoder.

Test Plan:
- Reset then idle -> in_rdy=1111, reqs=0000, holds=0000, out_val=0, err=0.
- Push 0xA1(last=1) on port 2; drive grants=0100 the next cycle -> reqs=0100 before grant; one cycle after grant out_val=1, out_msg=0xA1, out_src=2, out_last=1, reqs=0000, holds stays 0000.
- Port 0 pushes 3-beat packet 0x10,0x11,0x12(last) only one beat at a time with 2 idle cycles between beats; port 1 holds 0x20(last) -> holds=0001 from after first pop until last pop; out sees 0x10,0x11,0x12 from src 0 with bubbles; 0x20 emitted only after 0x12; err=0.
- Fill port 3 with DEPTH=2 beats, no grant -> in_rdy[3]=0, third in_val ignored; grant pops one -> in_rdy[3]=1 next cycle.
- Same-cycle push and pop on port 1 at count=1 -> count stays 1, order preserved (0x30 then 0x31).
- grants=0011 -> err=1 next cycle and remains 1; assert reset mid-packet with holds=0001 -> all FIFOs empty, holds=0000, err=0.
